issue_arbiter: RTL and testbench

- Schedules instruction issue from the three D2I queues (ALU, MEM, CTRL) onto the shared regfile read ports.
- Runs the single-outstanding-branch FSM and registers per-queue issue valids into I2A.
- Sits in ISSUE, between alu_queue/mem_queue/ctrl_queue and regfile/alu/d_cache.
- Requester index everywhere: 0=ALU, 1=MEM, 2=CTRL.

---
 rtl/issue_arbiter.sv | 149 ++++++++++++++
 tb/tb_issue_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/issue_arbiter.sv
// Issue arbiter: round-robin, port-budgeted issue of ALU/MEM/CTRL onto shared regfile read ports,
// plus the single-outstanding-branch FSM. Optional ISSUE_PERF_CNT_EN adds a conflict counter.
module issue_arbiter #(
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_REQ      = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [2*NUM_REQ-1:0]      i_src_cnt,
  input  logic                      i_mem_ready,
  input  logic                      i_br_resolve,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [2*NUM_RD_PORTS-1:0] o_port_owner,
  output logic [NUM_RD_PORTS-1:0]   o_port_src,
  output logic [NUM_REQ-1:0]        o_i2a_valid,
  output logic                      o_br_pending
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]               o_perf_conflicts
`endif
);

  typedef enum logic {ST_IDLE, ST_BR_PENDING} state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [1:0]                r_rr_ptr;
  logic [1:0]                w_rr_next;
  logic [NUM_REQ-1:0]        r_i2a_valid;
  logic [NUM_REQ-1:0]        w_elig;
  logic [NUM_REQ-1:0]        w_grant;
  logic [2*NUM_RD_PORTS-1:0] w_port_owner;
  logic [NUM_RD_PORTS-1:0]   w_port_src;
  logic [1:0]                w_last;
  logic                      w_any;
  logic                      w_ok;

  assign w_ok = !i_stall && !i_flush && !i_rst;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      // MEM waits for the d_cache; CTRL waits until no branch is outstanding.
      if (gi == 1) begin : g_mem
        assign w_elig[gi] = i_req[gi] && w_ok && i_mem_ready;
      end else if (gi == 2) begin : g_ctrl
        assign w_elig[gi] = i_req[gi] && w_ok && (r_state == ST_IDLE);
      end else begin : g_alu
        assign w_elig[gi] = i_req[gi] && w_ok;
      end
    end
  endgenerate

  always_comb begin
    logic [2:0] w_budget;
    logic [2:0] w_pidx;
    logic [2:0] w_sum;
    logic [1:0] w_idx;
    logic [1:0] w_cnt;
    w_grant      = '0;
    w_port_owner = '0;
    w_port_src   = '0;
    w_last       = r_rr_ptr;
    w_any        = 1'b0;
    w_budget     = 3'(NUM_RD_PORTS);
    w_pidx       = '0;
    w_sum        = '0;
    w_idx        = '0;
    w_cnt        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 3'(k);
      w_idx = (w_sum >= 3'(NUM_REQ)) ? 2'(w_sum - 3'(NUM_REQ)) : w_sum[1:0];
      w_cnt = i_src_cnt[{w_idx, 1'b0} +: 2];
      // A requester that does not fit is skipped, so cheaper ones behind it can still issue.
      if (w_elig[w_idx] && (w_cnt != 2'd3) && ({1'b0, w_cnt} <= w_budget)) begin
        w_grant[w_idx] = 1'b1;
        w_budget       = w_budget - {1'b0, w_cnt};
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
          if ((3'(p) >= w_pidx) && (3'(p) < w_pidx + {1'b0, w_cnt})) begin
            w_port_owner[2*p +: 2] = w_idx + 2'd1;
            w_port_src[p]          = (3'(p) != w_pidx);
          end
        end
        w_pidx = w_pidx + {1'b0, w_cnt};
        w_last = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_rr_next = r_rr_ptr;
    if (i_flush) begin
      w_rr_next = 2'd0;
    end else if (w_any) begin
      w_rr_next = (w_last == 2'(NUM_REQ - 1)) ? 2'd0 : w_last + 2'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant[2]) w_state_next = ST_BR_PENDING;
      end
      ST_BR_PENDING: begin
        // Resolve is honoured even under stall; CTRL only sees IDLE from the next cycle.
        if (i_br_resolve || i_flush) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 2'd0;
      r_i2a_valid <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rr_ptr    <= w_rr_next;
      r_i2a_valid <= i_flush ? '0 : w_grant;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] r_perf_conflicts;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_conflicts <= '0;
    end else if ((|(i_req & ~w_grant)) && !i_stall && !i_flush) begin
      r_perf_conflicts <= r_perf_conflicts + 32'd1;
    end
  end

  assign o_perf_conflicts = r_perf_conflicts;
`endif

  assign o_grant      = w_grant;
  assign o_port_owner = w_port_owner;
  assign o_port_src   = w_port_src;
  assign o_i2a_valid  = r_i2a_valid;
  assign o_br_pending = (r_state == ST_BR_PENDING);

endmodule

// File: tb/tb_issue_arbiter.sv
// Self-checking bench for issue_arbiter: vector table for the cycle-by-cycle sequence,
// scoreboard queue for the registered i2a_valid, plus hand-written reset sequences.
module tb_issue_arbiter;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [2:0]  req;
  logic [5:0]  src_cnt;
  logic        mem_ready;
  logic        br_resolve;
  logic [2:0]  grant;
  logic [3:0]  port_owner;
  logic [1:0]  port_src;
  logic [2:0]  i2a_valid;
  logic        br_pending;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_conflicts;
`endif

  int checks   = 0;
  int failures = 0;
  logic [2:0] sb_q[$];

  issue_arbiter #(.NUM_RD_PORTS(2), .NUM_REQ(3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_req        (req),
    .i_src_cnt    (src_cnt),
    .i_mem_ready  (mem_ready),
    .i_br_resolve (br_resolve),
    .o_grant      (grant),
    .o_port_owner (port_owner),
    .o_port_src   (port_src),
    .o_i2a_valid  (i2a_valid),
    .o_br_pending (br_pending)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .o_perf_conflicts (perf_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       stall;
    logic       flush;
    logic [2:0] req;
    logic [5:0] src;
    logic       mem_ready;
    logic       br_resolve;
    logic [2:0] grant;
    logic [3:0] owner;
    logic [1:0] psrc;
    logic       bp;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(logic s, logic f, logic [2:0] r, logic [5:0] sc, logic mr,
                              logic br, logic [2:0] g, logic [3:0] o, logic [1:0] ps, logic bp);
    vec_t v;
    v.stall = s; v.flush = f; v.req = r; v.src = sc; v.mem_ready = mr; v.br_resolve = br;
    v.grant = g; v.owner = o; v.psrc = ps; v.bp = bp;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h required %0h", name, idx, got, exp);
    end
  endtask

  task automatic apply(int idx, vec_t v);
    logic [2:0] exp_i2a;
    stall = v.stall; flush = v.flush; req = v.req; src_cnt = v.src;
    mem_ready = v.mem_ready; br_resolve = v.br_resolve;
    #1;
    check("grant", idx, 32'(grant), 32'(v.grant));
    check("port_owner", idx, 32'(port_owner), 32'(v.owner));
    check("port_src", idx, 32'(port_src), 32'(v.psrc));
    check("br_pending", idx, 32'(br_pending), 32'(v.bp));
    sb_q.push_back(v.flush ? 3'b000 : v.grant);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", idx, 32'd0, 32'd1);
    end else begin
      exp_i2a = sb_q.pop_front();
      check("i2a_valid", idx, 32'(i2a_valid), 32'(exp_i2a));
    end
    $display("vec %0d: req=%b src=%b stall=%b flush=%b grant=%b owner=%b psrc=%b i2a=%b",
             idx, v.req, v.src, v.stall, v.flush, grant, port_owner, port_src, i2a_valid);
    @(negedge clk);
  endtask

  initial begin
    // src_cnt layout {CTRL, MEM, ALU}; port_owner {port1, port0}
    vecs[0]  = mk(0,0,3'b111,6'b010101,1,1, 3'b011,4'b1001,2'b00,0); // rr0: ALU, MEM
    vecs[1]  = mk(0,0,3'b111,6'b010101,1,1, 3'b101,4'b0111,2'b00,0); // rr2: CTRL, ALU
    vecs[2]  = mk(0,0,3'b111,6'b010101,1,1, 3'b011,4'b0110,2'b00,1); // rr1, CTRL blocked
    vecs[3]  = mk(0,0,3'b100,6'b010101,1,0, 3'b100,4'b0011,2'b00,0); // CTRL issues
    vecs[4]  = mk(0,0,3'b100,6'b010101,1,0, 3'b000,4'b0000,2'b00,1);
    vecs[5]  = mk(0,0,3'b100,6'b010101,1,0, 3'b000,4'b0000,2'b00,1);
    vecs[6]  = mk(0,0,3'b100,6'b010101,1,1, 3'b000,4'b0000,2'b00,1); // resolve, still blocked
    vecs[7]  = mk(0,0,3'b100,6'b010101,1,0, 3'b100,4'b0011,2'b00,0); // CTRL next cycle
    vecs[8]  = mk(0,0,3'b000,6'b010101,1,1, 3'b000,4'b0000,2'b00,1);
    vecs[9]  = mk(0,0,3'b111,6'b000110,1,0, 3'b101,4'b0101,2'b10,0); // budget skip of MEM
    vecs[10] = mk(0,0,3'b010,6'b000110,1,0, 3'b010,4'b0010,2'b00,1); // MEM retries
    vecs[11] = mk(0,1,3'b111,6'b010101,1,0, 3'b000,4'b0000,2'b00,1); // flush in BR_PENDING, rr2
    vecs[12] = mk(0,0,3'b111,6'b010101,1,0, 3'b011,4'b1001,2'b00,0); // rr back to 0
    vecs[13] = mk(1,0,3'b111,6'b010101,1,0, 3'b000,4'b0000,2'b00,0); // stall
    vecs[14] = mk(0,0,3'b111,6'b010101,1,0, 3'b101,4'b0111,2'b00,0); // rr held at 2
    vecs[15] = mk(0,0,3'b010,6'b010101,0,1, 3'b000,4'b0000,2'b00,1); // mem not ready
    vecs[16] = mk(0,0,3'b010,6'b010101,1,0, 3'b010,4'b0010,2'b00,0);
    vecs[17] = mk(0,0,3'b001,6'b010111,1,0, 3'b000,4'b0000,2'b00,0); // illegal src_cnt=3
    vecs[18] = mk(0,0,3'b111,6'b100101,1,0, 3'b100,4'b1111,2'b10,0); // CTRL takes both ports
    vecs[19] = mk(1,0,3'b111,6'b010101,1,1, 3'b000,4'b0000,2'b00,1); // resolve under stall
    vecs[20] = mk(0,0,3'b100,6'b010101,1,0, 3'b100,4'b0011,2'b00,0);

    rst = 1'b1; stall = 1'b0; flush = 1'b0; req = 3'b111; src_cnt = 6'b010101;
    mem_ready = 1'b1; br_resolve = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("rst_grant", c, 32'(grant), 32'd0);
      check("rst_owner", c, 32'(port_owner), 32'd0);
      check("rst_i2a", c, 32'(i2a_valid), 32'd0);
      check("rst_bp", c, 32'(br_pending), 32'd0);
      $display("reset cycle %0d: grant=%b i2a=%b bp=%b", c, grant, i2a_valid, br_pending);
    end
    rst = 1'b0;

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // Reset while a branch is pending clears FSM, rr_ptr and i2a_valid.
    rst = 1'b1; req = 3'b111; src_cnt = 6'b010101; stall = 1'b0; flush = 1'b0; br_resolve = 1'b0;
    #1;
    check("rst2_grant", 0, 32'(grant), 32'd0);
    check("rst2_bp_before", 0, 32'(br_pending), 32'd1);
    @(posedge clk);
    #1;
    check("rst2_bp", 0, 32'(br_pending), 32'd0);
    check("rst2_i2a", 0, 32'(i2a_valid), 32'd0);
    $display("mid-run reset: bp=%b i2a=%b", br_pending, i2a_valid);
    @(negedge clk);
    rst = 1'b0;
    apply(NV, mk(0,0,3'b111,6'b010101,1,0, 3'b011,4'b1001,2'b00,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
